// File: rtl/pic_bus_pkg.sv
// pic_bus_pkg: shared types and constants for the synchronous 8259A-style
// data-bus control block (pic_bus_control_sync) and its pin synchroniser.
//   bus_state_t  : initialisation sequencer states
//   strobe_t     : one-cycle register-write strobes to the interrupt core
//   *_BIT        : bit positions inside the low data byte used for decode
package pic_bus_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } bus_state_t;

  // D4 set with A0=0 selects ICW1; D3 separates OCW3 from OCW2.
  localparam int ICW1_SEL_BIT = 4;
  localparam int OCW3_SEL_BIT = 3;
  // ICW1 fields latched at ICW1 time.
  localparam int SNGL_BIT     = 1;
  localparam int IC4_BIT      = 0;

  typedef struct packed {
    logic icw1;
    logic icw2;
    logic icw3;
    logic icw4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

endpackage

// File: rtl/pic_pin_sync.sv
// pic_pin_sync: STAGES-deep flop chain for bringing asynchronous bus pins into
// the core clock domain. Each bit resets to its own value from RST_VAL so the
// active-low control pins can come out of reset deasserted.
//   clk_i  : core clock
//   rst_i  : synchronous, active-high reset
//   d_i    : raw pin values
//   q_o    : synchronised values (last stage of the chain)
module pic_pin_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pic_bus_control_sync.sv
// pic_bus_control_sync: synchronous 8259A data-bus control logic.
// Samples CS#/RD#/WR#/A0/D on the core clock, latches write data while a
// write is active, and on the trailing edge of each write decodes it against
// the ICW1->ICW2->[ICW3]->[ICW4] initialisation sequence, producing one
// registered strobe per write.
//
// Parameters:
//   DATA_WIDTH  : CPU data width (>=8); only [7:0] is decoded, all forwarded
//   SYNC_STAGES : synchroniser depth (1..4)
// Ports:
//   clock, reset        : core clock, synchronous active-high reset
//   chip_select_n, read_enable_n, write_enable_n, address, data_bus_in
//                       : raw asynchronous CPU bus pins
//   internal_data_bus   : last captured write data
//   write_icw1..4, write_ocw1..3 : one-cycle write strobes
//   read                : level, synchronised CS#&RD# low with no write active
//   init_done           : initialisation complete (READY)
//   single_mode, icw4_needed : ICW1 SNGL / IC4 bits, latched
//   init_error          : one-cycle pulse when a write is ignored as illegal
//   read_end            : only with BUS_CTRL_RD_END_PULSE_EN defined; one-cycle
//                         pulse on the cycle after read falls
module pic_bus_control_sync
  import pic_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_icw1,
  output logic                  write_icw2,
  output logic                  write_icw3,
  output logic                  write_icw4,
  output logic                  write_ocw1,
  output logic                  write_ocw2,
  output logic                  write_ocw3,
  output logic                  read,
  output logic                  init_done,
  output logic                  single_mode,
  output logic                  icw4_needed,
  output logic                  init_error
`ifdef BUS_CTRL_RD_END_PULSE_EN
  ,
  output logic                  read_end
`endif
);

  // ---------------------------------------------------------------- sync
  logic                  cs_s, rd_s, wr_s, addr_s;
  logic [DATA_WIDTH-1:0] data_s;

  // Control pins are active low, so they come out of reset deasserted.
  pic_pin_sync #(
    .WIDTH   (3),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (3'b111)
  ) u_ctrl_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   ({chip_select_n, read_enable_n, write_enable_n}),
    .q_o   ({cs_s, rd_s, wr_s})
  );

  pic_pin_sync #(
    .WIDTH   (DATA_WIDTH + 1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_bus_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   ({address, data_bus_in}),
    .q_o   ({addr_s, data_s})
  );

  // ---------------------------------------------------------------- write capture
  logic                  wr_act, wr_evt;
  logic                  wr_act_q;
  logic                  a_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign wr_act = ~cs_s & ~wr_s;
  // Trailing edge of the write: whichever of CS#/WR# rises first ends it.
  assign wr_evt = wr_act_q & ~wr_act;

  // ---------------------------------------------------------------- decode
  bus_state_t state_q, state_d;
  strobe_t    strb_q, strb_d;
  logic       err_q, err_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [7:0] dec_byte;

  assign dec_byte = data_q[7:0];

  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    err_d   = 1'b0;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    if (wr_evt) begin
      if (!a_q && dec_byte[ICW1_SEL_BIT]) begin
        // ICW1 restarts initialisation from any state.
        strb_d.icw1 = 1'b1;
        sngl_d      = dec_byte[SNGL_BIT];
        ic4_d       = dec_byte[IC4_BIT];
        state_d     = WAIT_ICW2;
      end else begin
        unique case (state_q)
          UNINIT: err_d = 1'b1;
          WAIT_ICW2: begin
            if (a_q) begin
              strb_d.icw2 = 1'b1;
              if (!sngl_q)    state_d = WAIT_ICW3;
              else if (ic4_q) state_d = WAIT_ICW4;
              else            state_d = READY;
            end else begin
              err_d = 1'b1;
            end
          end
          WAIT_ICW3: begin
            if (a_q) begin
              strb_d.icw3 = 1'b1;
              state_d     = ic4_q ? WAIT_ICW4 : READY;
            end else begin
              err_d = 1'b1;
            end
          end
          WAIT_ICW4: begin
            if (a_q) begin
              strb_d.icw4 = 1'b1;
              state_d     = READY;
            end else begin
              err_d = 1'b1;
            end
          end
          READY: begin
            if (a_q)                         strb_d.ocw1 = 1'b1;
            else if (dec_byte[OCW3_SEL_BIT]) strb_d.ocw3 = 1'b1;
            else                             strb_d.ocw2 = 1'b1;
          end
          default: state_d = UNINIT;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= UNINIT;
      wr_act_q <= 1'b0;
      a_q      <= 1'b0;
      data_q   <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      sngl_q   <= 1'b0;
      ic4_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_act_q <= wr_act;
      if (wr_act) begin
        a_q    <= addr_s;
        data_q <= data_s;
      end
      strb_q   <= strb_d;
      err_q    <= err_d;
      sngl_q   <= sngl_d;
      ic4_q    <= ic4_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign internal_data_bus = data_q;
  assign write_icw1        = strb_q.icw1;
  assign write_icw2        = strb_q.icw2;
  assign write_icw3        = strb_q.icw3;
  assign write_icw4        = strb_q.icw4;
  assign write_ocw1        = strb_q.ocw1;
  assign write_ocw2        = strb_q.ocw2;
  assign write_ocw3        = strb_q.ocw3;
  assign init_error        = err_q;
  assign single_mode       = sngl_q;
  assign icw4_needed       = ic4_q;
  assign init_done         = (state_q == READY);
  // A simultaneous write takes priority over the read.
  assign read              = ~cs_s & ~rd_s & ~wr_act;

`ifdef BUS_CTRL_RD_END_PULSE_EN
  logic read_q;

  always_ff @(posedge clock) begin
    if (reset) read_q <= 1'b0;
    else       read_q <= read;
  end

  assign read_end = read_q & ~read;
`endif

endmodule

// File: tb/tb_pic_bus_control_sync.sv
module tb_pic_bus_control_sync;

  localparam int ND = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [15:0] din = '0;

  always #5 clock = ~clock;

  function automatic int ss_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // strobe vector bit order: 0 icw1,1 icw2,2 icw3,3 icw4,4 ocw1,5 ocw2,6 ocw3
  wire [6:0]  stb  [ND];
  wire [15:0] ibus [ND];
  wire        rd_o [ND], done [ND], sngl [ND], ic4o [ND], err [ND], rend [ND];
  wire [7:0]  ibus0;
  assign ibus[0] = {8'h00, ibus0};

  pic_bus_control_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u0 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(a0), .data_bus_in(din[7:0]),
    .internal_data_bus(ibus0),
    .write_icw1(stb[0][0]), .write_icw2(stb[0][1]), .write_icw3(stb[0][2]),
    .write_icw4(stb[0][3]), .write_ocw1(stb[0][4]), .write_ocw2(stb[0][5]),
    .write_ocw3(stb[0][6]), .read(rd_o[0]), .init_done(done[0]),
    .single_mode(sngl[0]), .icw4_needed(ic4o[0]), .init_error(err[0])
`ifdef BUS_CTRL_RD_END_PULSE_EN
    , .read_end(rend[0])
`endif
  );

  pic_bus_control_sync #(.DATA_WIDTH(16), .SYNC_STAGES(1)) u1 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(a0), .data_bus_in(din),
    .internal_data_bus(ibus[1]),
    .write_icw1(stb[1][0]), .write_icw2(stb[1][1]), .write_icw3(stb[1][2]),
    .write_icw4(stb[1][3]), .write_ocw1(stb[1][4]), .write_ocw2(stb[1][5]),
    .write_ocw3(stb[1][6]), .read(rd_o[1]), .init_done(done[1]),
    .single_mode(sngl[1]), .icw4_needed(ic4o[1]), .init_error(err[1])
`ifdef BUS_CTRL_RD_END_PULSE_EN
    , .read_end(rend[1])
`endif
  );

  pic_bus_control_sync #(.DATA_WIDTH(16), .SYNC_STAGES(4)) u2 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(a0), .data_bus_in(din),
    .internal_data_bus(ibus[2]),
    .write_icw1(stb[2][0]), .write_icw2(stb[2][1]), .write_icw3(stb[2][2]),
    .write_icw4(stb[2][3]), .write_ocw1(stb[2][4]), .write_ocw2(stb[2][5]),
    .write_ocw3(stb[2][6]), .read(rd_o[2]), .init_done(done[2]),
    .single_mode(sngl[2]), .icw4_needed(ic4o[2]), .init_error(err[2])
`ifdef BUS_CTRL_RD_END_PULSE_EN
    , .read_end(rend[2])
`endif
  );

`ifndef BUS_CTRL_RD_END_PULSE_EN
  assign rend[0] = 1'b0;
  assign rend[1] = 1'b0;
  assign rend[2] = 1'b0;
`endif

  int checks = 0, fails = 0;
  int cyc = 16;
  bit rst_edge, started;

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", nm, k, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Ideal zero-latency view of the bus at each sampled pin value; results are
  // pushed into a per-DUT history and read back with the DUT's pipeline delay.
  bit        m_init [ND];          // an ICW1 has been accepted
  bit [2:0]  m_pend [ND];          // still-owed ICWs: bit0 ICW2, bit1 ICW3, bit2 ICW4
  bit        m_sngl [ND], m_ic4 [ND], m_a [ND], m_pact [ND], m_prd [ND];
  bit [15:0] m_ibus [ND];
  bit [6:0]  h_stb  [ND][16];
  bit        h_err  [ND][16], h_done [ND][16], h_sngl [ND][16], h_ic4 [ND][16];
  bit        h_rd   [ND][16], h_rend [ND][16];
  bit [15:0] h_ibus [ND][16];

  int cnt_stb [ND][7];
  int cnt_err [ND], cnt_rd [ND], cnt_rend [ND], last_stb_cyc [ND];

  task automatic model_step(input int k);
    bit act, r, re, e;
    bit [6:0] s;
    bit [7:0] d8;
    int ix;
    ix = cyc & 15;
    if (reset) begin
      m_init[k] = 0; m_pend[k] = 0; m_sngl[k] = 0; m_ic4[k] = 0;
      m_a[k] = 0; m_pact[k] = 0; m_prd[k] = 0; m_ibus[k] = 0;
      h_stb[k][ix] = 0; h_err[k][ix] = 0; h_done[k][ix] = 0; h_sngl[k][ix] = 0;
      h_ic4[k][ix] = 0; h_rd[k][ix] = 0; h_rend[k][ix] = 0; h_ibus[k][ix] = 0;
      return;
    end
    act = !cs_n && !wr_n;
    if (act) begin
      m_ibus[k] = (k == 0) ? {8'h00, din[7:0]} : din;
      m_a[k]    = a0;
    end
    s = 0; e = 0;
    if (m_pact[k] && !act) begin
      d8 = m_ibus[k][7:0];
      if (!m_a[k] && d8[4]) begin
        s[0] = 1; m_sngl[k] = d8[1]; m_ic4[k] = d8[0]; m_init[k] = 1;
        m_pend[k] = {d8[0], !d8[1], 1'b1};
      end else if (m_pend[k] != 0) begin
        if (!m_a[k])             e = 1;
        else if (m_pend[k][0]) begin s[1] = 1; m_pend[k][0] = 0; end
        else if (m_pend[k][1]) begin s[2] = 1; m_pend[k][1] = 0; end
        else                   begin s[3] = 1; m_pend[k][2] = 0; end
      end else if (m_init[k]) begin
        if (m_a[k])     s[4] = 1;
        else if (d8[3]) s[6] = 1;
        else            s[5] = 1;
      end else begin
        e = 1;
      end
    end
    m_pact[k] = act;
    r  = !cs_n && !rd_n && !act;
    re = m_prd[k] && !r;
    m_prd[k] = r;
    h_stb[k][ix]  = s;         h_err[k][ix]  = e;
    h_done[k][ix] = m_init[k] && (m_pend[k] == 0);
    h_sngl[k][ix] = m_sngl[k]; h_ic4[k][ix]  = m_ic4[k];
    h_ibus[k][ix] = m_ibus[k]; h_rd[k][ix]   = r; h_rend[k][ix] = re;
  endtask

  // Model update on each rising edge, compare on the following falling edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      rst_edge = reset;
      if (reset) started = 1;
      for (int k = 0; k < ND; k++) model_step(k);
      @(negedge clock);
      if (started) begin
        for (int k = 0; k < ND; k++) begin
          int ia, ir;
          ia = (cyc - ss_of(k)) & 15;
          ir = (cyc - ss_of(k) + 1) & 15;
          if (rst_edge) begin
            chk("strobes", k, {9'd0, stb[k]}, 16'h0);
            chk("init_error", k, {15'd0, err[k]}, 16'h0);
            chk("init_done", k, {15'd0, done[k]}, 16'h0);
            chk("read", k, {15'd0, rd_o[k]}, 16'h0);
            chk("ibus", k, ibus[k], 16'h0);
          end else begin
            chk("strobes", k, {9'd0, stb[k]}, {9'd0, h_stb[k][ia]});
            chk("init_error", k, {15'd0, err[k]}, {15'd0, h_err[k][ia]});
            chk("init_done", k, {15'd0, done[k]}, {15'd0, h_done[k][ia]});
            chk("single_mode", k, {15'd0, sngl[k]}, {15'd0, h_sngl[k][ia]});
            chk("icw4_needed", k, {15'd0, ic4o[k]}, {15'd0, h_ic4[k][ia]});
            chk("ibus", k, ibus[k], h_ibus[k][ia]);
            chk("read", k, {15'd0, rd_o[k]}, {15'd0, h_rd[k][ir]});
`ifdef BUS_CTRL_RD_END_PULSE_EN
            chk("read_end", k, {15'd0, rend[k]}, {15'd0, h_rend[k][ir]});
`endif
          end
          for (int i = 0; i < 7; i++) if (stb[k][i]) cnt_stb[k][i]++;
          if (stb[k] != 0) last_stb_cyc[k] = cyc;
          if (err[k])  cnt_err[k]++;
          if (rd_o[k]) cnt_rd[k]++;
          if (rend[k]) cnt_rend[k]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  int dcyc;   // last edge that sampled the write still active
  int s_stb [ND][7];
  int s_err [ND], s_rd [ND], s_rend [ND];

  task automatic snap();
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < 7; i++) s_stb[k][i] = cnt_stb[k][i];
      s_err[k] = cnt_err[k]; s_rd[k] = cnt_rd[k]; s_rend[k] = cnt_rend[k];
    end
  endtask

  function automatic int dstb(input int k, input int i);
    return cnt_stb[k][i] - s_stb[k][i];
  endfunction

  function automatic int dstb_all(input int k);
    int t = 0;
    for (int i = 0; i < 7; i++) t += cnt_stb[k][i] - s_stb[k][i];
    return t;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      cs_n = 1; rd_n = 1; wr_n = 1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    cs_n = 1; rd_n = 1; wr_n = 1; reset = 1;
    repeat (n) @(negedge clock);
    reset = 0;
  endtask

  task automatic wr(input bit a, input logic [15:0] d, input int len, input bit csfirst, input int gap);
    @(negedge clock);
    cs_n = 0; wr_n = 0; a0 = a; din = d;
    repeat (len - 1) @(negedge clock);
    @(negedge clock);
    dcyc = cyc;
    if (csfirst) begin
      cs_n = 1;
      @(negedge clock);
      wr_n = 1;
    end else begin
      cs_n = 1; wr_n = 1;
    end
    din = 16'($urandom);
    idle(gap);
  endtask

  task automatic rdop(input int len, input bit with_wr, input int gap);
    @(negedge clock);
    cs_n = 0; rd_n = 0; a0 = 1; din = 16'($urandom);
    if (with_wr) wr_n = 0;
    repeat (len - 1) @(negedge clock);
    @(negedge clock);
    cs_n = 1; rd_n = 1; wr_n = 1;
    idle(gap);
  endtask

  initial begin
    do_reset(6);
    idle(12);
    // reset state, literal
    chk("reset_read", 0, {15'd0, rd_o[0]}, 16'h0);
    chk("reset_done", 0, {15'd0, done[0]}, 16'h0);
    chk("reset_strobes", 0, {9'd0, stb[0]}, 16'h0);
    chk("reset_ibus", 0, ibus[0], 16'h0);

    // UNINIT: non-ICW1 write is rejected
    snap();
    wr(1, 16'h0020, 2, 0, 8);
    chk("uninit_err", 0, 16'(cnt_err[0] - s_err[0]), 16'd1);
    chk("uninit_nostb", 0, 16'(dstb_all(0)), 16'd0);

    // single mode with ICW4
    snap();
    wr(0, 16'hA513, 2, 0, 3);
    wr(1, 16'h0008, 1, 1, 3);
    wr(1, 16'h0001, 2, 0, 8);
    chk("sngl_icw1", 0, 16'(dstb(0, 0)), 16'd1);
    chk("sngl_icw2", 0, 16'(dstb(0, 1)), 16'd1);
    chk("sngl_icw3", 0, 16'(dstb(0, 2)), 16'd0);
    chk("sngl_icw4", 0, 16'(dstb(0, 3)), 16'd1);
    chk("sngl_done", 0, {15'd0, done[0]}, 16'h1);
    chk("sngl_bits", 0, {14'd0, sngl[0], ic4o[0]}, 16'h3);
    for (int k = 0; k < ND; k++)
      chk("latency", k, 16'(last_stb_cyc[k] - dcyc), 16'(ss_of(k) + 1));

    // cascade, no ICW4
    snap();
    wr(0, 16'h0010, 1, 0, 3);
    wr(1, 16'h0020, 3, 0, 3);
    wr(1, 16'h0004, 1, 0, 8);
    chk("casc_icw2", 0, 16'(dstb(0, 1)), 16'd1);
    chk("casc_icw3", 0, 16'(dstb(0, 2)), 16'd1);
    chk("casc_done", 0, {15'd0, done[0]}, 16'h1);
    wr(1, 16'h12FF, 2, 0, 8);
    chk("ocw1", 0, 16'(dstb(0, 4)), 16'd1);
    chk("ocw1_ibus0", 0, ibus[0], 16'h00FF);
    chk("ocw1_ibus2", 2, ibus[2], 16'h12FF);

    // OCW2 / OCW3 / re-ICW1 in READY
    snap();
    wr(0, 16'hFF00, 2, 0, 8);
    chk("ocw2", 0, 16'(dstb(0, 5)), 16'd1);
    wr(0, 16'h0008, 2, 1, 8);
    chk("ocw3", 0, 16'(dstb(0, 6)), 16'd1);
    wr(0, 16'h0010, 2, 0, 8);
    chk("reicw1", 0, 16'(dstb(0, 0)), 16'd1);
    chk("reicw1_done", 0, {15'd0, done[0]}, 16'h0);
    wr(1, 16'h0000, 1, 0, 3);
    wr(1, 16'h0000, 1, 0, 8);

    // reads
    snap();
    rdop(1, 0, 8);
    chk("read_cycles", 0, 16'(cnt_rd[0] - s_rd[0]), 16'd1);
    chk("read_cycles_ss4", 2, 16'(cnt_rd[2] - s_rd[2]), 16'd1);
`ifdef BUS_CTRL_RD_END_PULSE_EN
    chk("read_end_pulses", 0, 16'(cnt_rend[0] - s_rend[0]), 16'd1);
`endif
    snap();
    rdop(2, 1, 8);
    chk("rdwr_read", 0, 16'(cnt_rd[0] - s_rd[0]), 16'd0);
    chk("rdwr_strobe", 0, 16'(dstb_all(0)), 16'd1);

    // reset in the middle of a write while waiting for ICW3
    wr(0, 16'h0010, 1, 0, 3);
    wr(1, 16'h0020, 1, 0, 8);
    snap();
    @(negedge clock);
    cs_n = 0; wr_n = 0; a0 = 1; din = 16'h0004;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    cs_n = 1; wr_n = 1;
    repeat (5) @(negedge clock);
    reset = 0;
    idle(10);
    for (int k = 0; k < ND; k++) chk("rst_mid_nostb", k, 16'(dstb_all(k)), 16'd0);
    wr(1, 16'h0004, 1, 0, 8);
    for (int k = 0; k < ND; k++) chk("rst_mid_uninit", k, 16'(cnt_err[k] - s_err[k]), 16'd1);

    // randomized traffic, checked every cycle against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [15:0] d;
      op = $urandom_range(0, 39);
      d  = 16'($urandom);
      if (op < 6)       wr(0, {d[15:5], 1'b1, d[3:0]}, $urandom_range(1, 3), 1'($urandom), $urandom_range(1, 3));
      else if (op < 26) wr(1'($urandom), d, $urandom_range(1, 3), 1'($urandom), $urandom_range(1, 3));
      else if (op < 34) rdop($urandom_range(1, 3), 0, $urandom_range(1, 3));
      else if (op < 38) rdop($urandom_range(1, 3), 1, $urandom_range(1, 3));
      else              do_reset($urandom_range(5, 7));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pic_bus_control_sync.md
Name: pic_bus_control_sync

Overview:
- Synchronous, parametrised successor to the 8259A data-bus control logic.
- Samples the asynchronous CPU bus pins (CS#, RD#, WR#, A0, D) on the PIC core clock.
- Detects write completion and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence in a state machine.
- Emits one-cycle write strobes for each ICW/OCW, plus a level read enable, to the interrupt core registers.

Parameters:
- DATA_WIDTH, 8, CPU data bus width; must be ≥8; only bits [7:0] are used for decode, all bits are forwarded.
- SYNC_STAGES, 2, flop depth of the pin synchroniser; legal range 1–4.

Ports:
- clock  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- chip_select_n  input  1  CS#, active low.
- read_enable_n  input  1  RD#, active low.
- write_enable_n  input  1  WR#, active low.
- address  input  1  A0.
- data_bus_in  input  DATA_WIDTH  CPU write data.
- internal_data_bus  output  DATA_WIDTH  last captured write data.
- write_icw1  output  1  one-cycle strobe.
- write_icw2  output  1  one-cycle strobe.
- write_icw3  output  1  one-cycle strobe.
- write_icw4  output  1  one-cycle strobe.
- write_ocw1  output  1  one-cycle strobe.
- write_ocw2  output  1  one-cycle strobe.
- write_ocw3  output  1  one-cycle strobe.
- read  output  1  level: synchronised CS# & RD# both low, and no write active.
- init_done  output  1  high in READY state.
- single_mode  output  1  ICW1 D1 (SNGL), latched.
- icw4_needed  output  1  ICW1 D0 (IC4), latched.
- init_error  output  1  one-cycle pulse when an illegal write is ignored.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Synchroniser flops: cs_n, rd_n, wr_n = 1; address and data = 0.
  - All strobes, read, init_done, single_mode, icw4_needed, init_error = 0.
  - internal_data_bus = 0.
  - State = UNINIT.
- Synchroniser: every pin passes through SYNC_STAGES flops. Signals suffixed _s below are the synchroniser outputs.
- wr_act = ~cs_s & ~wr_s.
  - While wr_act is high, internal_data_bus and a_q capture data_s/address_s every cycle.
  - Write event = wr_act registered high while the current wr_act is low (trailing edge, matching the 8259A latch-on-WR#-rise behaviour).
- Latency: a strobe asserts exactly one cycle after the write-event cycle. From the pin deassert, that is SYNC_STAGES+1 clocks. Each write produces at most one strobe.
- Decode at a write event (D = internal_data_bus[7:0]), any state: a_q=0 & D[4]=1 → write_icw1.
  - Latch single_mode=D[1] and icw4_needed=D[0].
  - Clear init_done; go to WAIT_ICW2.
- States and transitions:
  - UNINIT: any other write → init_error, stay.
  - WAIT_ICW2:
    - a_q=1 → write_icw2. Next state: WAIT_ICW3 if !single_mode; else WAIT_ICW4 if icw4_needed; else READY.
    - a_q=0 & D[4]=0 → init_error, stay.
  - WAIT_ICW3:
    - a_q=1 → write_icw3. Next state: WAIT_ICW4 if icw4_needed, else READY.
    - a_q=0 & D[4]=0 → init_error, stay.
  - WAIT_ICW4:
    - a_q=1 → write_icw4, go to READY.
    - a_q=0 & D[4]=0 → init_error, stay.
  - READY:
    - a_q=1 → write_ocw1.
    - a_q=0, D[4:3]=00 → write_ocw2.
    - a_q=0, D[4:3]=01 → write_ocw3.
    - All stay in READY.
- Simultaneous RD# and WR# asserted: write wins; read is held 0 while wr_act is high.
- A CS# deassert before WR# counts as a write end (the event fires on whichever deasserts first).
- Reset mid-write: the write is lost, state goes to UNINIT, and no strobe is produced after reset.
- Back-to-back writes: minimum one idle synchronised cycle between them; each is decoded independently.
- Data bits [DATA_WIDTH-1:8] never affect decode.

Optional Feature:
- Macro: BUS_CTRL_RD_END_PULSE_EN.
- Defined: adds output port read_end (1 bit).
  - One-cycle pulse on the cycle after read falls.
  - Used by the core to clear poll/ISR-read state.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pic_bus_pkg holds:
  - bus_state_t enum: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - Constants ICW1_SEL_BIT=4, OCW3_SEL_BIT=3, SNGL_BIT=1, IC4_BIT=0.
- One sub-module, pic_pin_sync: a parametrised SYNC_STAGES flop chain with a per-bit reset value. It is instantiated for the control pins (reset to 1) and for address/data (reset to 0).

Test Plan:
- Reset then idle 12 cycles → all outputs 0, init_done=0. Write A0=1, D=0x20 → init_error pulse, no strobe.
- ICW1 0x13 (SNGL=1, IC4=1), then A0=1 0x08, then A0=1 0x01 → write_icw1, write_icw2, write_icw4 in order; no write_icw3; init_done=1 after the ICW4 strobe.
- ICW1 0x10 (cascade, no IC4), then A0=1 0x20, then A0=1 0x04 → write_icw2 then write_icw3, READY; a next write A0=1 0xFF → write_ocw1, internal_data_bus=0xFF.
- In READY: A0=0 0x00 → write_ocw2; A0=0 0x08 → write_ocw3; A0=0 0x10 → write_icw1 and init_done falls.
- In READY: assert CS#/RD# 1 clock → read high for 1 cycle after SYNC_STAGES delay. Assert RD#+WR# together → read stays 0, one strobe. With the macro defined, read_end pulses once.
- Assert reset during WR# low in WAIT_ICW3 → no strobe, state UNINIT; repeat at SYNC_STAGES=1 and 4 with DATA_WIDTH=16, checking latency = SYNC_STAGES+1.
